// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - hazard-control and stage-control bundle for pipeline_sequencer
// Purpose: groups the hazard unit controls, memory/branch/halt status and the
//   resulting per-stage enables, clears, valid bits, gated write enables and counters.
// Modports:
//   slave  - the sequencer: receives controls/status, drives enables/clears/valids/counters
//   master - the surrounding pipeline: drives controls/status, receives the sequencer outputs
interface pipeline_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             PCWrite;
  logic             FDWrite;
  logic             DEFlush;
  logic             BrTaken_E;
  logic             MemReq_M;
  logic             DMEM_READY;
  logic             Halt_W;
  logic             WENraw_M;
  logic             WENraw_W;
  logic             PCEn;
  logic             FDEn;
  logic             DEEn;
  logic             EMEn;
  logic             MWEn;
  logic             FDClr;
  logic             DEClr;
  logic             MWClr;
  logic             V_D;
  logic             V_E;
  logic             V_M;
  logic             V_W;
  logic             WEN_M;
  logic             WEN_W;
  logic             Halted;
  logic [CNT_W-1:0] RetireCnt;
  logic [CNT_W-1:0] StallCnt;

  modport slave (
    input  PCWrite, FDWrite, DEFlush, BrTaken_E, MemReq_M, DMEM_READY,
           Halt_W, WENraw_M, WENraw_W,
    output PCEn, FDEn, DEEn, EMEn, MWEn, FDClr, DEClr, MWClr,
           V_D, V_E, V_M, V_W, WEN_M, WEN_W, Halted, RetireCnt, StallCnt
  );

  modport master (
    output PCWrite, FDWrite, DEFlush, BrTaken_E, MemReq_M, DMEM_READY,
           Halt_W, WENraw_M, WENraw_W,
    input  PCEn, FDEn, DEEn, EMEn, MWEn, FDClr, DEClr, MWClr,
           V_D, V_E, V_M, V_W, WEN_M, WEN_W, Halted, RetireCnt, StallCnt
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - 5-stage pipeline enable/clear/valid sequencer with retire and stall counters
// Purpose: turns hazard-unit controls, E-stage redirects and data-memory wait states
//   into per-stage register enables and clears, tracks stage valid bits, gates M/W
//   writes so bubbles never write, sequences bring-up and halt, counts retires/stalls.
// Ports:
//   CLK  - clock, rising edge
//   RSTN - asynchronous active-low reset
//   bus  - pipeline_sequencer_if.slave (controls in; enables, clears, valids, WENs,
//          Halted, RetireCnt, StallCnt out)
module pipeline_sequencer #(
  parameter int CNT_W = 32
) (
  input logic                  CLK,
  input logic                  RSTN,
  pipeline_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  state_t           state;
  logic             v_d, v_e, v_m, v_w;
  logic             halted;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic active;
  logic memwait;
  logic redirect;
  logic load_use;
  logic pc_en, fd_en, de_en, em_en, mw_en;
  logic fd_clr, de_clr, mw_clr;
  logic stall_inc;

  // Enables and clears react to the current inputs with no added latency.
  always_comb begin
    active    = (state == ST_RUN) || (state == ST_MEMWAIT);
    memwait   = v_m & bus.MemReq_M & ~bus.DMEM_READY;
    redirect  = v_e & bus.BrTaken_E;
    load_use  = ~bus.PCWrite | ~bus.FDWrite | bus.DEFlush;
    pc_en     = 1'b0;
    fd_en     = 1'b0;
    de_en     = 1'b0;
    em_en     = 1'b0;
    mw_en     = 1'b0;
    fd_clr    = 1'b0;
    de_clr    = 1'b0;
    mw_clr    = 1'b0;
    stall_inc = 1'b0;
    if (active) begin
      if (memwait) begin
        // F..M freeze while the access is outstanding; W receives a bubble.
        mw_clr    = 1'b1;
        stall_inc = 1'b1;
      end else if (redirect) begin
        // The D instruction is wrong-path, so a concurrent load-use stall is moot.
        {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
        fd_clr = 1'b1;
        de_clr = 1'b1;
      end else if (load_use) begin
        pc_en     = bus.PCWrite;
        fd_en     = bus.FDWrite;
        de_clr    = bus.DEFlush;
        de_en     = 1'b1;
        em_en     = 1'b1;
        mw_en     = 1'b1;
        stall_inc = ~bus.PCWrite;
      end else begin
        {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ST_IDLE;
      v_d        <= 1'b0;
      v_e        <= 1'b0;
      v_m        <= 1'b0;
      v_w        <= 1'b0;
      halted     <= 1'b0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_RUN;
        ST_RUN, ST_MEMWAIT: begin
          if (v_w && bus.Halt_W) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (memwait) begin
            state <= ST_MEMWAIT;
          end else begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_HALT;
      endcase
      // Enables and clears are all zero in IDLE/HALT, so valid bits hold there.
      v_d <= fd_clr ? 1'b0 : (fd_en ? 1'b1 : v_d);
      v_e <= de_clr ? 1'b0 : (de_en ? v_d : v_e);
      v_m <= em_en ? v_e : v_m;
      v_w <= mw_clr ? 1'b0 : (mw_en ? v_m : v_w);
      if (active && v_w) retire_cnt <= retire_cnt + 1'b1;
      if (stall_inc)     stall_cnt  <= stall_cnt + 1'b1;
    end
  end

  assign bus.PCEn      = pc_en;
  assign bus.FDEn      = fd_en;
  assign bus.DEEn      = de_en;
  assign bus.EMEn      = em_en;
  assign bus.MWEn      = mw_en;
  assign bus.FDClr     = fd_clr;
  assign bus.DEClr     = de_clr;
  assign bus.MWClr     = mw_clr;
  assign bus.V_D       = v_d;
  assign bus.V_E       = v_e;
  assign bus.V_M       = v_m;
  assign bus.V_W       = v_w;
  // Active-low writes: a bubble or a halted core never writes.
  assign bus.WEN_M     = bus.WENraw_M | ~v_m | halted;
  assign bus.WEN_W     = bus.WENraw_W | ~v_w | halted;
  assign bus.Halted    = halted;
  assign bus.RetireCnt = retire_cnt;
  assign bus.StallCnt  = stall_cnt;

endmodule
